// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the phase-increment stream of a DDS.
// Steps start->stop with a programmable dwell; single, sawtooth-loop and up/down triangle modes.
module dds_sweep_ctrl #(
  parameter int G_DIN_WIDTH   = 24,
  parameter int G_DWELL_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [G_DIN_WIDTH-1:0]   start_freq,
  input  logic [G_DIN_WIDTH-1:0]   stop_freq,
  input  logic [G_DIN_WIDTH-1:0]   step,
  input  logic [G_DWELL_WIDTH-1:0] dwell,
  output logic                     dds_enable,
  output logic [G_DIN_WIDTH-1:0]   dds_din,
  output logic                     dds_din_valid,
  input  logic                     dds_din_ready,
  output logic                     busy,
  output logic                     done
);
  localparam int W = G_DIN_WIDTH;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [1:0] MODE_LOOP = 2'd1;
  localparam logic [1:0] MODE_UPDN = 2'd2;
  localparam logic signed [W:0] S_ZERO = '0;
  localparam logic [G_DWELL_WIDTH-1:0] DWELL_ONE = {{(G_DWELL_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]               state_r;
  logic [W-1:0]             cur_r;
  logic [W-1:0]             start_cfg_r;
  logic [W-1:0]             stop_cfg_r;
  logic [W-1:0]             step_cfg_r;
  logic [1:0]               mode_cfg_r;
  logic [G_DWELL_WIDTH-1:0] dwell_last_r;
  logic [G_DWELL_WIDTH-1:0] dwell_cnt_r;
  logic                     dir_r;   // 0: leg heads to stop_freq, 1: back to start_freq
  logic                     done_r;

  logic signed [W:0] cur_ext_s;
  logic signed [W:0] step_cur_s;
  logic signed [W:0] leg_end_s;
  logic signed [W:0] turn_end_s;
  logic signed [W:0] nxt_s;
  logic signed [W:0] turn_s;
  logic              xfer_s;
  logic              dwell_end_s;
  logic              seg_end_s;
  logic              turn_ok_s;

  function automatic logic signed [W:0] sext(input logic [W-1:0] v);
    sext = $signed({v[W-1], v});
  endfunction

  assign xfer_s      = (state_r == ST_RUN) && dds_din_ready;
  assign dwell_end_s = (dwell_cnt_r == dwell_last_r);

  // Next value, leg-end test and turning value, all one bit wider so nothing wraps.
  always_comb begin
    cur_ext_s = sext(cur_r);
    if (dir_r) begin
      step_cur_s = -sext(step_cfg_r);
      leg_end_s  = sext(start_cfg_r);
      turn_end_s = sext(stop_cfg_r);
    end else begin
      step_cur_s = sext(step_cfg_r);
      leg_end_s  = sext(stop_cfg_r);
      turn_end_s = sext(start_cfg_r);
    end
    nxt_s  = cur_ext_s + step_cur_s;
    turn_s = cur_ext_s - step_cur_s;
    if (step_cur_s > S_ZERO) begin
      seg_end_s = (nxt_s > leg_end_s);
      turn_ok_s = (turn_s >= turn_end_s);
    end else if (step_cur_s < S_ZERO) begin
      seg_end_s = (nxt_s < leg_end_s);
      turn_ok_s = (turn_s <= turn_end_s);
    end else begin
      seg_end_s = (start_cfg_r == stop_cfg_r);
      turn_ok_s = 1'b1;
    end
  end

  // Sweep state, configuration capture and value stepping; a one-value leg holds at the turn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cur_r        <= '0;
      start_cfg_r  <= '0;
      stop_cfg_r   <= '0;
      step_cfg_r   <= '0;
      mode_cfg_r   <= 2'd0;
      dwell_last_r <= '0;
      dwell_cnt_r  <= '0;
      dir_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
      end else if (state_r == ST_IDLE) begin
        if (start) begin
          state_r      <= ST_RUN;
          start_cfg_r  <= start_freq;
          stop_cfg_r   <= stop_freq;
          step_cfg_r   <= step;
          mode_cfg_r   <= mode;
          dwell_last_r <= (dwell == '0) ? '0 : (dwell - DWELL_ONE);
          cur_r        <= start_freq;
          dwell_cnt_r  <= '0;
          dir_r        <= 1'b0;
        end
      end else if (xfer_s) begin
        if (!dwell_end_s) begin
          dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
        end else begin
          dwell_cnt_r <= '0;
          if (!seg_end_s) begin
            cur_r <= nxt_s[W-1:0];
          end else begin
            case (mode_cfg_r)
              MODE_LOOP: cur_r <= start_cfg_r;
              MODE_UPDN: begin
                dir_r <= ~dir_r;
                if (turn_ok_s) begin
                  cur_r <= turn_s[W-1:0];
                end
              end
              default: begin
                state_r <= ST_IDLE;
                done_r  <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

  assign dds_enable    = (state_r == ST_RUN);
  assign dds_din_valid = (state_r == ST_RUN);
  assign busy          = (state_r == ST_RUN);
  assign dds_din       = cur_r;
  assign done          = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sequences plus randomized sweeps checked every cycle
// against a reference that lists the expected accepted increments from the sweep rules.
module tb_dds_sweep_ctrl;
  localparam int W = 24;
  localparam int DW = 16;
  localparam int LIMIT = 1200;

  logic          clk = 1'b0;
  logic          reset, start, abort, dds_din_ready;
  logic [1:0]    mode;
  logic [W-1:0]  start_freq, stop_freq, step;
  logic [DW-1:0] dwell;
  logic          dds_enable, dds_din_valid, busy, done;
  logic [W-1:0]  dds_din;

  int n_tests = 0;
  int n_fail = 0;
  int seq[$];
  bit seq_fin;
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  int m_idx = 0;
  int acc_q[$];
  int done_cnt = 0;
  int e8[8];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.G_DIN_WIDTH(W), .G_DWELL_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .start_freq(start_freq), .stop_freq(stop_freq), .step(step), .dwell(dwell),
    .dds_enable(dds_enable), .dds_din(dds_din), .dds_din_valid(dds_din_valid),
    .dds_din_ready(dds_din_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected accepted-value list: each sweep value repeated dwell times, periods repeated.
  function automatic void build(input int s, input int e, input int st, input int dw, input int md);
    int leg[$];
    int per[$];
    int v;
    int de;
    de = (dw == 0) ? 1 : dw;
    leg.push_back(s);
    if (st != 0) begin
      v = s + st;
      while (((st > 0) && (v <= e)) || ((st < 0) && (v >= e))) begin
        leg.push_back(v);
        v = v + st;
      end
    end
    per = leg;
    if (md == 2) begin
      for (int k = leg.size() - 2; k >= 1; k--) per.push_back(leg[k]);
    end
    seq_fin = ((md == 0) || (md == 3)) && !((st == 0) && (s != e));
    seq.delete();
    for (int r = 0; r < LIMIT; r++) begin
      foreach (per[k]) for (int d = 0; d < de; d++) seq.push_back(per[k]);
      if (seq_fin || (seq.size() >= LIMIT)) break;
    end
  endfunction

  task automatic set_cfg(input int md, input int s, input int e, input int st, input int dw);
    mode = md[1:0];
    start_freq = s[W-1:0];
    stop_freq = e[W-1:0];
    step = st[W-1:0];
    dwell = dw[DW-1:0];
  endtask

  function automatic void model_step(input logic i_rst, input logic i_start, input logic i_abort, input logic i_ready);
    if (!i_rst) begin
      m_run = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (i_abort) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (i_start) begin
          build(int'($signed(start_freq)), int'($signed(stop_freq)), int'($signed(step)),
                int'(dwell), int'(mode));
          m_idx = 0;
          m_run = 1'b1;
        end
      end else if (i_ready) begin
        m_idx++;
        if (seq_fin && (m_idx >= seq.size())) begin
          m_run = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endfunction

  // One clock: drive inputs, advance the reference, then compare after the edge.
  task automatic tick(input logic i_rst, input logic i_start, input logic i_abort, input logic i_ready);
    reset = i_rst;
    start = i_start;
    abort = i_abort;
    dds_din_ready = i_ready;
    if (i_rst && !i_abort && i_ready && (dds_din_valid === 1'b1))
      acc_q.push_back(int'($signed(dds_din)));
    model_step(i_rst, i_start, i_abort, i_ready);
    @(posedge clk);
    @(negedge clk);
    chk("valid", dds_din_valid, m_run);
    chk("enable", dds_enable, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    if (m_run && (m_idx < seq.size())) chk("din", $signed(dds_din), seq[m_idx]);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run(input int ncyc, input int rmode);
    for (int i = 0; i < ncyc; i++) begin
      logic r;
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) r = ~i[0];
      else r = ($urandom_range(0, 9) < 7);
      tick(1'b1, 1'b0, 1'b0, r);
      if (!m_run && !m_done) break;
    end
  endtask

  task automatic begin_test(input int md, input int s, input int e, input int st, input int dw);
    set_cfg(md, s, e, st, dw);
    acc_q.delete();
    done_cnt = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic check_acc(input string name, input int n, input bit exact);
    if (exact) chk({name, "_len"}, acc_q.size(), n);
    for (int i = 0; i < n; i++)
      chk(name, (i < acc_q.size()) ? acc_q[i] : -999999, e8[i]);
  endtask

  initial begin
    set_cfg(0, 0, 0, 0, 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0; dds_din_ready = 1'b0;

    // Reset held 3 cycles, start asserted in the middle one
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_din", $signed(dds_din), 0);
    chk("rst_valid", dds_din_valid, 0);
    chk("rst_done", done, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);

    // Single sweep, dwell 2
    begin_test(0, 0, 30, 10, 2);
    run(30, 0);
    e8 = '{0, 0, 10, 10, 20, 20, 30, 30};
    check_acc("single", 8, 1'b1);
    chk("single_done", done_cnt, 1);

    // Loop with ready toggling
    begin_test(1, -5, 5, 5, 1);
    run(20, 1);
    e8 = '{-5, 0, 5, -5, 0, 5, -5, 0};
    check_acc("loop", 8, 1'b0);
    chk("loop_done", done_cnt, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    // Up/down triangle
    begin_test(2, 0, 20, 10, 1);
    run(12, 0);
    e8 = '{0, 10, 20, 10, 0, 10, 20, 10};
    check_acc("updown", 8, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    // Abort mid-dwell together with a transfer and start, then restart
    begin_test(1, 100, 200, 10, 3);
    run(2, 0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_valid", dds_din_valid, 0);
    chk("abort_done", done, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_restart", $signed(dds_din), 100);
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    // Edge cases
    begin_test(0, 0, 2, 1, 0);
    run(10, 0);
    e8 = '{0, 1, 2, 0, 0, 0, 0, 0};
    check_acc("dwell0", 3, 1'b1);
    begin_test(0, 0, 20, 7, 1);
    run(10, 0);
    e8 = '{0, 7, 14, 0, 0, 0, 0, 0};
    check_acc("step7", 3, 1'b1);
    begin_test(0, 0, 5, -1, 1);
    run(10, 0);
    e8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_acc("wrongsign", 1, 1'b1);
    chk("wrongsign_done", done_cnt, 1);
    begin_test(0, 32'h7FFFF0, 32'h7FFFFF, 8, 1);
    run(10, 0);
    e8 = '{8388592, 8388600, 0, 0, 0, 0, 0, 0};
    check_acc("ovf_pos", 2, 1'b1);
    begin_test(0, -8388603, -8388608, -4, 1);
    run(10, 0);
    e8 = '{-8388603, -8388607, 0, 0, 0, 0, 0, 0};
    check_acc("ovf_neg", 2, 1'b1);
    begin_test(0, 4, 4, 0, 2);
    run(10, 0);
    e8 = '{4, 4, 0, 0, 0, 0, 0, 0};
    check_acc("step0_eq", 2, 1'b1);
    begin_test(0, 3, 9, 0, 1);
    run(20, 0);
    chk("tone_len", acc_q.size(), 20);
    chk("tone_done", done_cnt, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized sweeps with stray starts, config churn, aborts and resets
    for (int it = 0; it < 40; it++) begin
      int md, s, e, st, span, mag;
      md = $urandom_range(0, 3);
      s = int'($urandom_range(0, 120)) - 60;
      span = $urandom_range(0, 60);
      mag = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) begin e = s + span; st = mag; end
      else begin e = s - span; st = -mag; end
      if ($urandom_range(0, 9) == 0) st = -st;
      set_cfg(md, s, e, st, $urandom_range(0, 3));
      tick(1'b1, 1'b1, 1'b0, $urandom_range(0, 1) == 1);
      for (int c = 0; c < 150; c++) begin
        set_cfg($urandom_range(0, 3), int'($urandom_range(0, 120)) - 60,
                int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 16)) - 8,
                $urandom_range(0, 3));
        tick($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7);
      end
      tick(1'b1, 1'b0, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
